n64a_blur_estimator: RTL and testbench

Parametrised successor of the VI de-blur estimator in the N64 PPU front end. It samples the raw N64 video bus and detects reversals of sharp colour gradients on alternate pixels, which indicate that the N64 VI is not blurring. It accumulates a per-frame score into a saturating trend and applies hysteresis thresholds, producing `ndo_deblur_o` for the downstream de-blur/blanking logic. Compared with the previous generation, it adds configurable width, channel masking, hysteresis and settling frames, and keeps its own previous-pixel storage.

---
 rtl/n64a_blur_estimator.sv | 164 ++++++++++++++++
 tb/tb_n64a_blur_estimator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/n64a_blur_estimator.sv
// Estimates whether the N64 VI is blurring by watching gradient reversals on
// alternate pixels; a per-frame score drives a saturating trend with hysteresis.
`timescale 1ns/1ps
module n64a_blur_estimator #(
  parameter int COLOR_W       = 7,
  parameter int CMP_BITS      = 3,
  parameter int SCORE_W       = 4,
  parameter int TREND_W       = 10,
  parameter int HYST_SHIFT    = 2,
  parameter int SUB_GAP       = 1,
  parameter int SETTLE_FRAMES = 1
) (
  input  logic               VCLK,
  input  logic               nRST,
  input  logic               nVDSYNC,
  input  logic [COLOR_W-1:0] VD_i,
  input  logic [1:0]         data_cnt_i,
  input  logic               vmode_i,
  input  logic               n64_480i_i,
  input  logic [15:0]        cfg_i,
  output logic               ndo_deblur_o,
  output logic               nblur_o,
  output logic [TREND_W-1:0] trend_o,
  output logic               est_valid_o
);

  localparam int CW = ((SCORE_W > 4) ? SCORE_W : 4) + 1;
  localparam int TW = TREND_W + 1;
  localparam int SW = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);
  localparam logic [TREND_W-1:0] C_TREND  = {1'b1, {(TREND_W-1){1'b0}}};
  localparam logic [SW:0]        SETTLE_X = (SW+1)'(SETTLE_FRAMES);

  logic [2:0]          w_ph, w_flip, w_fmask;
  logic [CMP_BITS-1:0] w_cur;
  logic                w_sync, w_cs_rise, w_frame_edge, w_pix_hit, w_auto;
  logic                w_inc, w_dec, w_set, w_clr, w_unused;
  logic [1:0]          w_nflip, w_min;
  logic [CW-1:0]       w_score_x, w_add_x;
  logic [TW-1:0]       w_h, w_trend_x, w_c_x;
  logic [SW:0]         w_settle_nx;

  logic                r_prev_vs, r_prev_cs, r_blur_pix;
  logic [SCORE_W-1:0]  r_score;
  logic [SW-1:0]       r_settle;
  logic                r_est, r_nblur, r_ndo;
  logic [TREND_W-1:0]  r_trend;

  assign w_sync = ~nVDSYNC;
  // w_ph bit order matches ch_en = {R,G,B}
  assign w_ph   = {nVDSYNC && (data_cnt_i == 2'd1),
                   nVDSYNC && (data_cnt_i == 2'd2),
                   nVDSYNC && (data_cnt_i == 2'd3)};
  assign w_cur  = VD_i[COLOR_W-1 -: CMP_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [CMP_BITS-1:0] r_prev;
      logic [1:0]          r_grad;
      logic                r_flip;
      logic [1:0]          w_grad;
      logic                w_en;

      assign w_en   = cfg_i[6+gi];
      assign w_grad = {r_prev < w_cur, r_prev > w_cur};

      always_ff @(posedge VCLK or negedge nRST) begin
        if (!nRST) begin
          r_prev <= '0;
          r_grad <= '0;
          r_flip <= 1'b0;
        end else begin
          if (w_ph[gi]) r_prev <= w_cur;
          if (n64_480i_i || (w_sync && !r_blur_pix)) begin
            r_flip <= 1'b0;
          end else if (w_ph[gi] && w_en) begin
            if (r_blur_pix)                      r_grad <= w_grad;
            else if ((w_grad ^ r_grad) == 2'b11) r_flip <= 1'b1;
          end
        end
      end

      assign w_flip[gi] = r_flip;
    end
  endgenerate

  assign w_fmask      = w_flip & cfg_i[8:6];
  assign w_nflip      = 2'(w_fmask[0]) + 2'(w_fmask[1]) + 2'(w_fmask[2]);
  assign w_min        = (cfg_i[5:4] == 2'd0) ? 2'd1 : cfg_i[5:4];
  assign w_pix_hit    = w_sync && !r_blur_pix && (w_nflip >= w_min);
  assign w_cs_rise    = w_sync && !r_prev_cs && VD_i[0];
  assign w_frame_edge = w_sync && r_prev_vs && !VD_i[3];
  assign w_auto       = (cfg_i[1:0] == 2'b00);

  assign w_score_x = CW'(r_score);
  assign w_add_x   = CW'(cfg_i[12:9]);
  assign w_inc     = w_score_x >= w_add_x;
  assign w_dec     = (w_score_x + CW'(SUB_GAP)) < w_add_x;

  // Widened by one bit so C+H and C-H cannot wrap; the set test is checked first.
  assign w_h       = TW'(cfg_i[15:13]) << HYST_SHIFT;
  assign w_c_x     = {1'b0, C_TREND};
  assign w_trend_x = {1'b0, r_trend};
  assign w_set     = w_trend_x >= (w_c_x + w_h);
  assign w_clr     = (w_h <= w_c_x) && (w_trend_x <= (w_c_x - w_h));

  assign w_settle_nx = {1'b0, r_settle} + (SW+1)'(1);
  assign w_unused    = ^{cfg_i[3], VD_i};

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      r_prev_vs  <= 1'b0;
      r_prev_cs  <= 1'b0;
      r_blur_pix <= 1'b0;
      r_score    <= '0;
      r_settle   <= '0;
      r_est      <= 1'b0;
      r_trend    <= C_TREND;
      r_nblur    <= 1'b1;
      r_ndo      <= 1'b0;
    end else begin
      if (w_sync) begin
        r_prev_vs  <= VD_i[3];
        r_prev_cs  <= VD_i[0];
        r_blur_pix <= w_cs_rise ? ~vmode_i : ~r_blur_pix;
      end
      if (w_frame_edge)
        r_ndo <= n64_480i_i | (w_auto ? r_nblur : ~cfg_i[1]);

      if (n64_480i_i) begin
        r_score  <= '0;
        r_settle <= '0;
        r_est    <= 1'b0;
        if (cfg_i[2]) begin
          r_trend <= C_TREND;
          r_nblur <= 1'b1;
        end
      end else if (w_frame_edge) begin
        // A pixel closing on this same sync word loses its increment.
        r_score <= '0;
        if (r_est) begin
          if (w_inc) begin
            if (r_trend != '1) r_trend <= r_trend + TREND_W'(1);
          end else if (w_dec && (r_trend != '0)) begin
            r_trend <= r_trend - TREND_W'(1);
          end
          if (w_set)      r_nblur <= 1'b1;
          else if (w_clr) r_nblur <= 1'b0;
        end else begin
          r_settle <= w_settle_nx[SW-1:0];
          if (w_settle_nx >= SETTLE_X) r_est <= 1'b1;
        end
      end else if (w_pix_hit && (r_score != '1)) begin
        r_score <= r_score + SCORE_W'(1);
      end
    end
  end

  assign ndo_deblur_o = r_ndo;
  assign nblur_o      = r_nblur;
  assign trend_o      = r_trend;
  assign est_valid_o  = r_est;

endmodule

// File: tb/tb_n64a_blur_estimator.sv
// Directed bench for n64a_blur_estimator: drives N64 bus frames and checks
// trend, hysteresis, settling, 480i handling, forced modes and reset.
`timescale 1ns/1ps
module tb_n64a_blur_estimator;

  localparam int FLAT  = 0;
  localparam int SHARP = 1;
  localparam int RAMP  = 2;

  logic        VCLK = 1'b0;
  logic        nRST;
  logic        nVDSYNC;
  logic [6:0]  VD_i;
  logic [1:0]  data_cnt_i;
  logic        vmode_i;
  logic        n64_480i_i;
  logic [15:0] cfg_i;
  logic        ndo_deblur_o;
  logic        nblur_o;
  logic [9:0]  trend_o;
  logic        est_valid_o;

  int errors = 0;
  int checks = 0;

  n64a_blur_estimator dut (
    .VCLK         (VCLK),
    .nRST         (nRST),
    .nVDSYNC      (nVDSYNC),
    .VD_i         (VD_i),
    .data_cnt_i   (data_cnt_i),
    .vmode_i      (vmode_i),
    .n64_480i_i   (n64_480i_i),
    .cfg_i        (cfg_i),
    .ndo_deblur_o (ndo_deblur_o),
    .nblur_o      (nblur_o),
    .trend_o      (trend_o),
    .est_valid_o  (est_valid_o)
  );

  always #5 VCLK = ~VCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mk(input logic [1:0] mode, input logic clr,
                                     input logic [1:0] minc, input logic [2:0] chen,
                                     input logic [3:0] addth, input logic [2:0] hyst);
    return {hyst, addth, chen, minc, 1'b0, clr, mode};
  endfunction

  function automatic logic [6:0] rval(input int kind, input int k, input int n);
    if (kind == SHARP) return (k % 2 == 1) ? 7'h70 : 7'h00;
    if (kind == RAMP)  return (k < n - 1) ? 7'(k * 16) : 7'h00;
    return 7'h00;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic word(input logic nsync, input logic [1:0] cnt, input logic [6:0] vd);
    nVDSYNC    = nsync;
    data_cnt_i = cnt;
    VD_i       = vd;
    @(posedge VCLK);
    #1;
  endtask

  task automatic pix(input logic vs, input logic cs, input logic [6:0] r);
    word(1'b0, 2'd0, {3'b000, vs, 2'b00, cs});
    word(1'b1, 2'd1, r);
    word(1'b1, 2'd2, 7'h00);
    word(1'b1, 2'd3, 7'h00);
  endtask

  // Line-start pixel, n data pixels, then the nVSYNC-falling sync word.
  task automatic frame(input int kind, input int n);
    pix(1'b1, 1'b0, 7'h00);
    for (int k = 0; k < n; k++) pix(1'b1, 1'b1, rval(kind, k, n));
    word(1'b0, 2'd0, 7'b0000001);
  endtask

  initial begin
    nRST = 1'b0; nVDSYNC = 1'b1; data_cnt_i = 2'd0; VD_i = 7'h00;
    vmode_i = 1'b0; n64_480i_i = 1'b0;
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b100, 4'd2, 3'd0);
    #1;

    // Reset held for 3 cycles while bus words flow
    word(1'b0, 2'd0, 7'b0001001);
    word(1'b1, 2'd1, 7'h70);
    word(1'b1, 2'd2, 7'h00);
    chk("rst_ndo", 16'(ndo_deblur_o), 16'd0);
    chk("rst_nblur", 16'(nblur_o), 16'd1);
    chk("rst_trend", 16'(trend_o), 16'd512);
    chk("rst_valid", 16'(est_valid_o), 16'd0);
    nRST = 1'b1;

    // Sharp alternation: first edge only settles
    frame(SHARP, 7);
    $display("sharp f1: trend=%0d valid=%0d ndo=%0d", trend_o, est_valid_o, ndo_deblur_o);
    chk("sharp_f1_valid", 16'(est_valid_o), 16'd1);
    chk("sharp_f1_trend", 16'(trend_o), 16'd512);
    chk("sharp_f1_ndo", 16'(ndo_deblur_o), 16'd1);
    frame(SHARP, 7);
    $display("sharp f2: trend=%0d nblur=%0d", trend_o, nblur_o);
    chk("sharp_f2_trend", 16'(trend_o), 16'd513);
    chk("sharp_f2_nblur", 16'(nblur_o), 16'd1);
    frame(SHARP, 7);
    $display("sharp f3: trend=%0d ndo=%0d", trend_o, ndo_deblur_o);
    chk("sharp_f3_trend", 16'(trend_o), 16'd514);
    chk("sharp_f3_ndo", 16'(ndo_deblur_o), 16'd1);

    // min_chg, channel mask and dead-zone cases
    cfg_i = mk(2'b00, 1'b0, 2'd2, 3'b100, 4'd2, 3'd0);
    frame(SHARP, 7);
    $display("minchg2: trend=%0d", trend_o);
    chk("minchg2_trend", 16'(trend_o), 16'd513);
    cfg_i = mk(2'b00, 1'b0, 2'd0, 3'b100, 4'd2, 3'd0);
    frame(SHARP, 7);
    $display("minchg0: trend=%0d", trend_o);
    chk("minchg0_trend", 16'(trend_o), 16'd514);
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b000, 4'd2, 3'd0);
    frame(SHARP, 7);
    $display("chen0: trend=%0d", trend_o);
    chk("chen0_trend", 16'(trend_o), 16'd513);
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b010, 4'd2, 3'd0);
    frame(SHARP, 7);
    $display("chen_g: trend=%0d", trend_o);
    chk("chen_g_trend", 16'(trend_o), 16'd512);
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b100, 4'd3, 3'd0);
    frame(SHARP, 7);
    $display("deadzone: trend=%0d nblur=%0d", trend_o, nblur_o);
    chk("deadzone_trend", 16'(trend_o), 16'd512);
    chk("deadzone_nblur", 16'(nblur_o), 16'd1);

    // Blurred ramp with H=8
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b111, 4'd2, 3'd2);
    for (int i = 0; i < 8; i++) frame(RAMP, 7);
    $display("ramp x8: trend=%0d nblur=%0d", trend_o, nblur_o);
    chk("ramp8_trend", 16'(trend_o), 16'd504);
    chk("ramp8_nblur", 16'(nblur_o), 16'd1);
    frame(RAMP, 7);
    $display("ramp x9: trend=%0d nblur=%0d ndo=%0d", trend_o, nblur_o, ndo_deblur_o);
    chk("ramp9_trend", 16'(trend_o), 16'd503);
    chk("ramp9_nblur", 16'(nblur_o), 16'd0);
    chk("ramp9_ndo", 16'(ndo_deblur_o), 16'd1);
    frame(RAMP, 7);
    $display("ramp x10: trend=%0d ndo=%0d", trend_o, ndo_deblur_o);
    chk("ramp10_trend", 16'(trend_o), 16'd502);
    chk("ramp10_ndo", 16'(ndo_deblur_o), 16'd0);
    frame(SHARP, 7);
    $display("hyst hold: trend=%0d nblur=%0d", trend_o, nblur_o);
    chk("hold_trend", 16'(trend_o), 16'd503);
    chk("hold_nblur", 16'(nblur_o), 16'd0);

    // Forced modes take effect only at the next frame edge
    cfg_i = mk(2'b01, 1'b0, 2'd1, 3'b111, 4'd2, 3'd2);
    pix(1'b1, 1'b0, 7'h00);
    chk("force1_pre_ndo", 16'(ndo_deblur_o), 16'd0);
    word(1'b0, 2'd0, 7'b0000001);
    $display("force01: ndo=%0d trend=%0d", ndo_deblur_o, trend_o);
    chk("force1_ndo", 16'(ndo_deblur_o), 16'd1);
    cfg_i = mk(2'b10, 1'b0, 2'd1, 3'b111, 4'd2, 3'd2);
    frame(FLAT, 0);
    $display("force10: ndo=%0d trend=%0d", ndo_deblur_o, trend_o);
    chk("force0_ndo", 16'(ndo_deblur_o), 16'd0);
    chk("force0_trend", 16'(trend_o), 16'd501);

    // 480i with clear-on-480i
    cfg_i = mk(2'b00, 1'b1, 2'd1, 3'b111, 4'd2, 3'd2);
    n64_480i_i = 1'b1;
    pix(1'b1, 1'b0, 7'h00);
    chk("i480_trend", 16'(trend_o), 16'd512);
    chk("i480_nblur", 16'(nblur_o), 16'd1);
    chk("i480_valid", 16'(est_valid_o), 16'd0);
    word(1'b0, 2'd0, 7'b0000001);
    $display("480i edge: ndo=%0d trend=%0d", ndo_deblur_o, trend_o);
    chk("i480_ndo", 16'(ndo_deblur_o), 16'd1);
    n64_480i_i = 1'b0;
    frame(FLAT, 0);
    $display("240p edge1: trend=%0d valid=%0d", trend_o, est_valid_o);
    chk("p240_e1_trend", 16'(trend_o), 16'd512);
    chk("p240_e1_valid", 16'(est_valid_o), 16'd1);
    frame(FLAT, 0);
    $display("240p edge2: trend=%0d", trend_o);
    chk("p240_e2_trend", 16'(trend_o), 16'd511);

    // Score saturates at 15 (19 flips in the frame) and still meets add_th=15
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b111, 4'd15, 3'd0);
    frame(SHARP, 41);
    $display("score sat: trend=%0d nblur=%0d", trend_o, nblur_o);
    chk("score_sat_trend", 16'(trend_o), 16'd512);
    chk("score_sat_nblur", 16'(nblur_o), 16'd0);

    // Trend saturation at both ends
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b111, 4'd0, 3'd0);
    for (int i = 0; i < 520; i++) frame(FLAT, 0);
    $display("trend top: trend=%0d nblur=%0d", trend_o, nblur_o);
    chk("trend_top", 16'(trend_o), 16'd1023);
    chk("trend_top_nblur", 16'(nblur_o), 16'd1);
    cfg_i = mk(2'b00, 1'b0, 2'd1, 3'b111, 4'd2, 3'd0);
    for (int i = 0; i < 1030; i++) frame(FLAT, 0);
    $display("trend bottom: trend=%0d nblur=%0d", trend_o, nblur_o);
    chk("trend_bot", 16'(trend_o), 16'd0);
    chk("trend_bot_nblur", 16'(nblur_o), 16'd0);

    // Asynchronous reset mid-frame, then settling restarts
    word(1'b1, 2'd1, 7'h70);
    nRST = 1'b0;
    #1;
    chk("arst_trend", 16'(trend_o), 16'd512);
    chk("arst_nblur", 16'(nblur_o), 16'd1);
    chk("arst_valid", 16'(est_valid_o), 16'd0);
    chk("arst_ndo", 16'(ndo_deblur_o), 16'd0);
    word(1'b1, 2'd2, 7'h00);
    word(1'b1, 2'd3, 7'h00);
    nRST = 1'b1;
    frame(FLAT, 0);
    $display("post-rst edge1: trend=%0d valid=%0d", trend_o, est_valid_o);
    chk("prst_e1_valid", 16'(est_valid_o), 16'd1);
    chk("prst_e1_trend", 16'(trend_o), 16'd512);
    frame(FLAT, 0);
    $display("post-rst edge2: trend=%0d", trend_o);
    chk("prst_e2_trend", 16'(trend_o), 16'd511);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
